full_subtractor_20: RTL and testbench
=====================================

// Module: full_subtractor_20
// PURPOSE
//  - Unsigned/two's-complement subtractor for the UrCPU ALU arithmetic path: Diff = A - B - Bin.
//  - Built as a ripple chain of 1-bit full-subtractor cells.
//  - Result and borrow-out are registered, giving a fixed 1-cycle latency.
//  - Feeds the ALU result mux; Bout drives the borrow/carry flag logic.
// PARAMETERS
//  - WIDTH  20  operand and result width in bits (>= 1)
// PORTS
//  - clk       in   1      system clock; all state updates on rising edge
//  - rst_n     in   1      asynchronous, active-low reset
//  - in_valid  in   1      A/B/Bin are valid this cycle
//  - A         in   WIDTH  minuend, unsigned
//  - B         in   WIDTH  subtrahend, unsigned
//  - Bin       in   1      borrow-in, subtracted at bit 0
//  - Diff      out  WIDTH  registered (A - B - Bin) mod 2^WIDTH
//  - Bout      out  1      registered borrow-out of the MSB cell
//  - out_valid out  1      Diff/Bout hold a result computed from in_valid inputs
// BEHAVIOUR
//  - Reset: rst_n low asynchronously forces Diff=0, Bout=0, out_valid=0.
//    - Held while rst_n is low.
//    - The first capture is on the first rising clk edge after rst_n goes high.
//  - Bit cell i: d[i] = A[i]^B[i]^b[i].
//    - b[i+1] = (~A[i]&B[i]) | (~(A[i]^B[i])&b[i]).
//    - b[0] = Bin; Bout = b[WIDTH].
//  - Combinational chain: no internal state; the only flops are the output registers.
//  - Arithmetic meaning:
//    - Bout = 1 iff A < B + Bin (unsigned compare, WIDTH+1-bit sum).
//    - Diff is the low WIDTH bits of A - B - Bin, i.e. wrap-around on underflow.
//  - Capture: every rising edge with in_valid=1 registers Diff, Bout and sets out_valid=1.
//  - Idle: on a rising edge with in_valid=0, out_valid is cleared and Diff/Bout hold their previous values.
//  - Latency: exactly 1 clk from inputs to Diff/Bout/out_valid.
//    - Throughput: one operation per cycle.
//    - No backpressure.
//  - Inputs are sampled only at the clock edge; glitches between edges have no effect.
//  - Reset mid-operation: in-flight result is discarded; outputs go to reset values immediately.
//  - X on inputs with in_valid=0 must not propagate into Diff/Bout.
// TESTING
//  - After reset release: Diff=0, Bout=0, out_valid=0 until the first valid input.
//  - A=11, B=6, Bin=0, in_valid=1 -> next cycle Diff=5 (0x00005), Bout=0, out_valid=1.
//  - A=6, B=6, Bin=1 -> Diff=0xFFFFF, Bout=1 (underflow wraps).
//  - A=15, B=15, Bin=0 -> Diff=0x00000, Bout=0.
//  - Extremes:
//    - A=0, B=0xFFFFF, Bin=1 -> Diff=0x00000, Bout=1.
//    - A=0xFFFFF, B=0, Bin=0 -> Diff=0xFFFFF, Bout=0.
//  - Assert rst_n low between two valid cycles -> outputs clear immediately.
//    - in_valid=0 cycles then hold the previous Diff/Bout with out_valid=0.
//    - Randomised check vs. {Bout,Diff} = {1'b0,A} - {1'b0,B} - Bin.

Source files
------------

// File: rtl/full_subtractor_20.sv
`default_nettype none
// ============================================================================
//  Module      : full_subtractor_20_cell
//  Description : One-bit full-subtractor cell. Produces the difference bit
//                d = a ^ b ^ bin and the borrow passed to the next more
//                significant cell.
//  Ports       : a    - minuend bit
//                b    - subtrahend bit
//                bin  - borrow from the less significant cell
//                d    - difference bit
//                bout - borrow to the more significant cell
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_20_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_a_xor_b;

    assign w_a_xor_b = a ^ b;
    assign d         = w_a_xor_b ^ bin;

    // A borrow is generated when a=0,b=1. When a and b are equal, the
    // incoming borrow propagates unchanged. When a=1,b=0, any incoming
    // borrow is absorbed.
    assign bout = (~a & b) | (~w_a_xor_b & bin);

endmodule

// ============================================================================
//  Module      : full_subtractor_20
//  Description : Registered ripple-borrow subtractor for the ALU arithmetic
//                path: Diff = (A - B - Bin) mod 2^WIDTH, with Bout the borrow
//                out of the most significant cell. Fixed one-cycle latency,
//                one operation per cycle, no backpressure.
//  Parameters  : WIDTH     - operand / result width in bits (>= 1)
//  Ports       : clk       - system clock, rising edge active
//                rst_n     - asynchronous active-low reset
//                in_valid  - A/B/Bin are valid this cycle
//                A         - minuend (unsigned)
//                B         - subtrahend (unsigned)
//                Bin       - borrow-in, subtracted at bit 0
//                Diff      - registered difference
//                Bout      - registered borrow-out (1 iff A < B + Bin)
//                out_valid - Diff/Bout hold a result from a valid input
//  Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor_20 #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             out_valid
);

    // ------------------------------------------------------------------------
    // Combinational ripple chain. w_borrow[i] is the borrow entering cell i;
    // w_borrow[WIDTH] is the borrow leaving the MSB cell.
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_borrow[0] = Bin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_subtractor_20_cell u_cell (
                .a    (A[gi]),
                .b    (B[gi]),
                .bin  (w_borrow[gi]),
                .d    (w_diff[gi]),
                .bout (w_borrow[gi+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output registers. The result registers load only when in_valid is high,
    // so unknown operands presented on idle cycles never reach Diff/Bout;
    // they simply retain the last captured result. out_valid follows
    // in_valid one cycle later.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_diff <= w_diff;
                r_bout <= w_borrow[WIDTH];
            end
        end
    end

    assign Diff      = r_diff;
    assign Bout      = r_bout;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_full_subtractor_20.sv
`default_nettype none
// ============================================================================
//  Module      : tb_full_subtractor_20
//  Description : Self-checking bench for full_subtractor_20. Directed vectors
//                with hand-computed results, reset and idle-hold behaviour,
//                followed by back-to-back random operands against a
//                wide-arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_full_subtractor_20;

    localparam int c_width = 20;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic [c_width-1:0] A;
    logic [c_width-1:0] B;
    logic               Bin;
    logic [c_width-1:0] Diff;
    logic               Bout;
    logic               out_valid;

    int checks = 0;
    int errors = 0;

    full_subtractor_20 #(.WIDTH(c_width)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .Diff      (Diff),
        .Bout      (Bout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive operands at the falling edge, then return 1 time unit after the
    // following rising edge so the registered result can be sampled.
    task automatic apply(input logic [c_width-1:0] a, input logic [c_width-1:0] b,
                         input logic bin, input logic v);
        @(negedge clk);
        A        = a;
        B        = b;
        Bin      = bin;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [c_width-1:0] d,
                              input logic bo, input logic ov);
        chk({tag, "_diff"}, 32'(Diff), 32'(d));
        chk({tag, "_bout"}, 32'(Bout), 32'(bo));
        chk({tag, "_ovld"}, 32'(out_valid), 32'(ov));
    endtask

    initial begin
        logic [c_width-1:0] ra;
        logic [c_width-1:0] rb;
        logic               rbin;
        logic [c_width:0]   rref;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        Bin      = 1'b0;

        // Reset held: outputs at reset values.
        repeat (3) @(posedge clk);
        #1;
        expect_out("in_reset", 20'h00000, 1'b0, 1'b0);

        // Release at a falling edge; an idle cycle keeps everything clear.
        @(negedge clk);
        rst_n = 1'b1;
        apply(20'h00000, 20'h00000, 1'b0, 1'b0);
        expect_out("post_reset", 20'h00000, 1'b0, 1'b0);

        // Directed vectors.
        apply(20'd11, 20'd6, 1'b0, 1'b1);
        expect_out("a11_b6", 20'h00005, 1'b0, 1'b1);
        apply(20'd6, 20'd6, 1'b1, 1'b1);
        expect_out("a6_b6_bin", 20'hFFFFF, 1'b1, 1'b1);
        apply(20'd15, 20'd15, 1'b0, 1'b1);
        expect_out("a15_b15", 20'h00000, 1'b0, 1'b1);
        apply(20'h00000, 20'hFFFFF, 1'b1, 1'b1);
        expect_out("zero_minus_max", 20'h00000, 1'b1, 1'b1);
        apply(20'hFFFFF, 20'h00000, 1'b0, 1'b1);
        expect_out("max_minus_zero", 20'hFFFFF, 1'b0, 1'b1);
        apply(20'h12345, 20'h00345, 1'b1, 1'b1);
        expect_out("mid_borrow", 20'h11FFF, 1'b0, 1'b1);
        apply(20'h80000, 20'h80001, 1'b0, 1'b1);
        expect_out("msb_underflow", 20'hFFFFF, 1'b1, 1'b1);
        apply(20'h00000, 20'h00000, 1'b1, 1'b1);
        expect_out("zero_bin_only", 20'hFFFFF, 1'b1, 1'b1);
        apply(20'hA5A5A, 20'h5A5A5, 1'b0, 1'b1);
        expect_out("alt_pattern", 20'h4B4B5, 1'b0, 1'b1);
        apply(20'hFFFFF, 20'hFFFFF, 1'b1, 1'b1);
        expect_out("max_max_bin", 20'hFFFFF, 1'b1, 1'b1);

        // Idle cycles with unknown operands hold the last result.
        apply(20'd11, 20'd6, 1'b0, 1'b1);
        expect_out("pre_idle", 20'h00005, 1'b0, 1'b1);
        apply('x, 'x, 1'bx, 1'b0);
        expect_out("idle_x_1", 20'h00005, 1'b0, 1'b0);
        apply('x, 'x, 1'bx, 1'b0);
        expect_out("idle_x_2", 20'h00005, 1'b0, 1'b0);

        // Asynchronous reset between two valid cycles.
        apply(20'h00010, 20'h00001, 1'b1, 1'b1);
        expect_out("pre_async", 20'h0000E, 1'b0, 1'b1);
        @(negedge clk);
        A        = 20'h00000;
        B        = 20'h00001;
        Bin      = 1'b0;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("async_clear", 20'h00000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("reset_held_valid", 20'h00000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        apply(20'h00003, 20'h00001, 1'b0, 1'b0);
        expect_out("post_async_idle", 20'h00000, 1'b0, 1'b0);
        apply(20'h00003, 20'h00001, 1'b0, 1'b1);
        expect_out("post_async_valid", 20'h00002, 1'b0, 1'b1);

        // Back-to-back random operands against wide arithmetic.
        for (int i = 0; i < 32; i++) begin
            ra   = c_width'($urandom);
            rb   = (i % 4 == 0) ? ra : c_width'($urandom);
            rbin = 1'($urandom_range(0, 1));
            rref = {1'b0, ra} - {1'b0, rb} - {{c_width{1'b0}}, rbin};
            apply(ra, rb, rbin, 1'b1);
            expect_out("random", rref[c_width-1:0], rref[c_width], 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
